// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared control-word layout for the decoder and pipeline stages
package mips_pkg;

    localparam int CTRL_W = 9;

    // Bit positions within the decoder control word, MSB first
    localparam int CTRL_REGDST   = 8;
    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_BRANCH   = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_JUMP     = 1;
    localparam int CTRL_HLT      = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = 9'b0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard check against the EX instruction
module load_use_detect (
    input  logic       mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    output logic       hz
);

    // Register zero is hardwired, so a load targeting it never creates a dependency
    assign hz = mem_read && (ex_rt != 5'd0) && ((ex_rt == rs) || (ex_rt == rt));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, halt latch and stall counter
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CTRL_W-1:0]      ctrl_in,
    input  logic [DATA_W-1:0]      pc4_in,
    input  logic [DATA_W-1:0]      rd1_in,
    input  logic [DATA_W-1:0]      rd2_in,
    input  logic [DATA_W-1:0]      imm_in,
    input  logic [4:0]             rs_in,
    input  logic [4:0]             rt_in,
    input  logic [4:0]             rd_in,
    input  logic                   flush_in,
    output logic [CTRL_W-1:0]      ex_ctrl,
    output logic [DATA_W-1:0]      ex_pc4,
    output logic [DATA_W-1:0]      ex_rd1,
    output logic [DATA_W-1:0]      ex_rd2,
    output logic [DATA_W-1:0]      ex_imm,
    output logic [4:0]             ex_rs,
    output logic [4:0]             ex_rt,
    output logic [4:0]             ex_rd,
    output logic                   stall_out,
    output logic                   halted_out,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic hz;
    logic bubble;

    load_use_detect u_load_use_detect (
        .mem_read (ex_ctrl[CTRL_MEMREAD]),
        .ex_rt    (ex_rt),
        .rs       (rs_in),
        .rt       (rt_in),
        .hz       (hz)
    );

    assign stall_out = halted_out | (hz & ~flush_in);
    assign bubble    = halted_out | flush_in | hz;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl     <= CTRL_NOP;
            ex_pc4      <= '0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            halted_out  <= 1'b0;
            stall_count <= '0;
        end else if (bubble) begin
            // Zeroed data fields keep a bubble from re-triggering the hazard check
            ex_ctrl <= CTRL_NOP;
            ex_pc4  <= '0;
            ex_rd1  <= '0;
            ex_rd2  <= '0;
            ex_imm  <= '0;
            ex_rs   <= '0;
            ex_rt   <= '0;
            ex_rd   <= '0;
            if (!halted_out && !flush_in && hz && (stall_count != {STALL_CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
        end else begin
            ex_ctrl <= ctrl_in;
            ex_pc4  <= pc4_in;
            ex_rd1  <= rd1_in;
            ex_rd2  <= rd2_in;
            ex_imm  <= imm_in;
            ex_rs   <= rs_in;
            ex_rt   <= rt_in;
            ex_rd   <= rd_in;
            if (ctrl_in[CTRL_HLT]) begin
                halted_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized self-checking bench for id_ex_stage against a behavioural model
module tb_id_ex_stage;

    localparam int DW   = 32;
    localparam int CW   = 10;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [8:0] W_ADD = 9'b100001000;
    localparam logic [8:0] W_LW  = 9'b010101100;
    localparam logic [8:0] W_SW  = 9'b010010000;
    localparam logic [8:0] W_BEQ = 9'b001000000;
    localparam logic [8:0] W_J   = 9'b000000010;
    localparam logic [8:0] W_HLT = 9'b000000001;

    logic          clk = 1'b0;
    logic          reset;
    logic [8:0]    ctrl_in;
    logic [DW-1:0] pc4_in, rd1_in, rd2_in, imm_in;
    logic [4:0]    rs_in, rt_in, rd_in;
    logic          flush_in;
    logic [8:0]    ex_ctrl;
    logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic          stall_out, halted_out;
    logic [CW-1:0] stall_count;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [8:0]    ctrl;
        logic [DW-1:0] pc4, rd1, rd2, imm;
        logic [4:0]    rs, rt, rd;
    } ex_t;

    ex_t m_ex;
    bit  m_halted;
    int  m_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .STALL_CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .pc4_in(pc4_in),
        .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush_in(flush_in),
        .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .stall_out(stall_out), .halted_out(halted_out), .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one ID word, check the combinational stall, clock, then check every EX output.
    task automatic apply(input logic [8:0] c, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic f, input logic r,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit hazard, exp_stall;
        reset = r; ctrl_in = c; rs_in = s; rt_in = t; rd_in = d; flush_in = f;
        rd1_in = a; rd2_in = b; pc4_in = $urandom; imm_in = $urandom;
        hazard = m_ex.ctrl[5] && (m_ex.rt != 0) && ((m_ex.rt == s) || (m_ex.rt == t));
        exp_stall = m_halted || (hazard && !f);
        #1;
        check("stall_out", 64'(stall_out), 64'(exp_stall));
        @(posedge clk);
        if (r) begin
            m_ex = '{default: '0};
            m_halted = 0;
            m_cnt = 0;
        end else if (m_halted || f || hazard) begin
            if (!m_halted && !f) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            m_ex = '{default: '0};
        end else begin
            m_ex = '{c, pc4_in, a, b, imm_in, s, t, d};
            if (c[0]) m_halted = 1;
        end
        #1;
        check("ex_ctrl", 64'(ex_ctrl), 64'(m_ex.ctrl));
        check("ex_pc4", 64'(ex_pc4), 64'(m_ex.pc4));
        check("ex_rd1", 64'(ex_rd1), 64'(m_ex.rd1));
        check("ex_rd2", 64'(ex_rd2), 64'(m_ex.rd2));
        check("ex_imm", 64'(ex_imm), 64'(m_ex.imm));
        check("ex_regs", {49'b0, ex_rs, ex_rt, ex_rd}, {49'b0, m_ex.rs, m_ex.rt, m_ex.rd});
        check("halted_out", 64'(halted_out), 64'(m_halted));
        check("stall_count", 64'(stall_count), 64'(m_cnt));
    endtask

    initial begin
        logic [8:0] pool [6];
        logic [8:0] c;
        pool = '{W_ADD, W_LW, W_SW, W_BEQ, W_J, 9'h0};
        m_ex = '{default: '0};
        m_halted = 0;
        m_cnt = 0;
        reset = 1; ctrl_in = 0; pc4_in = 0; rd1_in = 0; rd2_in = 0; imm_in = 0;
        rs_in = 0; rt_in = 0; rd_in = 0; flush_in = 0;
        @(posedge clk);
        #1;

        // Reset state
        apply(W_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 32'd9, 32'd9);
        check("rst_ctrl", 64'(ex_ctrl), 64'd0);

        // Pass-through of an add word
        apply(W_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'd5, 32'd7);
        check("pt_ctrl", 64'(ex_ctrl), 64'h108);
        check("pt_rd1", 64'(ex_rd1), 64'd5);
        check("pt_rd2", 64'(ex_rd2), 64'd7);

        // Load-use: lw rt=8 then dependent rs=8 stalls once, then captures
        apply(W_LW, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 32'd1, 32'd2);
        apply(W_ADD, 5'd8, 5'd3, 5'd4, 1'b0, 1'b0, 32'd3, 32'd4);
        check("lu_bubble", 64'(ex_ctrl), 64'd0);
        check("lu_cnt", 64'(stall_count), 64'd1);
        apply(W_ADD, 5'd8, 5'd3, 5'd4, 1'b0, 1'b0, 32'd3, 32'd4);
        check("lu_capture", 64'(ex_ctrl), 64'h108);

        // Register zero never creates a dependency
        apply(W_LW, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 32'd1, 32'd2);
        apply(W_ADD, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 32'd6, 32'd6);
        check("rt0_capture", 64'(ex_ctrl), 64'h108);

        // Flush wins over a hazard and does not count
        apply(W_LW, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0, 32'd1, 32'd2);
        apply(W_ADD, 5'd9, 5'd9, 5'd4, 1'b1, 1'b0, 32'd6, 32'd6);
        check("flush_bubble", 64'(ex_ctrl), 64'd0);
        check("flush_cnt", 64'(stall_count), 64'd1);

        // Halt: HLT visible for one cycle, then bubbles until reset
        apply(W_HLT, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'd1, 32'd1);
        check("hlt_ctrl", 64'(ex_ctrl), 64'd1);
        check("hlt_flag", 64'(halted_out), 64'd1);
        apply(W_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'd5, 32'd7);
        check("hlt_block", 64'(ex_ctrl), 64'd0);
        check("hlt_stall", 64'(stall_out), 64'd1);

        // Reset mid-stream with a load sitting in EX
        apply(W_LW, 5'd1, 5'd8, 5'd0, 1'b0, 1'b1, 32'd1, 32'd2);
        apply(W_LW, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 32'd1, 32'd2);
        apply(W_LW, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 32'd1, 32'd2);
        check("rst_mid_ctrl", 64'(ex_ctrl), 64'd0);
        check("rst_mid_halt", 64'(halted_out), 64'd0);
        check("rst_mid_cnt", 64'(stall_count), 64'd0);

        // Randomized traffic with small register indices so dependencies are frequent
        for (int i = 0; i < 3000; i++) begin
            c = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) c = 9'($urandom) & 9'h1FE;
            if ($urandom_range(0, 149) == 0) c = W_HLT;
            apply(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                  $urandom, $urandom);
        end

        // Saturation: repeated self-dependent loads
        apply(W_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'd0, 32'd0);
        for (int i = 0; i < 2 * (CMAX + 3) + 2; i++) begin
            apply(W_LW, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, $urandom, $urandom);
        end
        check("sat_cnt", 64'(stall_count), 64'(CMAX));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
